shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
Parametrised arbiter that lets NUM_PORTS requesters share the single-ported memoria_compartilhada. Typical requesters are the MEM-stage data port and the IF-stage fetch port. It replaces ad-hoc IF/MEM muxing with a registered request/grant handshake, configurable memory latency, and per-port stall outputs that feed the hazard logic (PCWrite/IFIDWrite). It sits between the CPU pipeline stages and the memory instance.

Parameters:
NUM_PORTS, 2, number of requesters; legal range 2..8; port 0 is highest fixed priority (data port).
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 1, cycles the memory needs per access; legal values >= 1.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset_n  input  1  synchronous active-low reset.
req  input  NUM_PORTS  per-port access request; must be held until the port's gnt is seen.
we  input  NUM_PORTS  per-port write enable (1 = write, 0 = read); held with req.
addr  input  NUM_PORTS*ADDR_W  packed addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
wdata  input  NUM_PORTS*DATA_W  packed write data; same packing as addr.
gnt  output  NUM_PORTS  one-hot; pulses for 1 cycle when a port's request is accepted.
rvalid  output  NUM_PORTS  one-hot; pulses for 1 cycle when read data for that port is on rdata.
rdata  output  DATA_W  registered read data; holds last value.
stall  output  NUM_PORTS  stall[i] = (req[i] & ~gnt[i]) | (rd_pend[i] & ~rvalid[i]); combinational.
mem_addr  output  ADDR_W  memory address, registered.
mem_wdata  output  DATA_W  memory write data, registered.
mem_rd  output  1  memory read strobe, registered.
mem_wr  output  1  memory write strobe, registered.
mem_rdata  input  DATA_W  memory read data; valid in the last ACCESS cycle.

Behaviour:
- Reset (reset_n low at posedge): state=IDLE; gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_wdata=0, mem_rd=0, mem_wr=0; cnt=0; rd_pend=0; rr_ptr=0.
- Reset mid-access aborts the access: strobes drop on that edge, no rvalid, and the in-flight read is lost.
- FSM states: IDLE and ACCESS.
- IDLE, any req high at posedge:
  - Select winner w.
  - Register mem_addr/mem_wdata from port w, mem_rd=~we[w], mem_wr=we[w].
  - gnt[w]=1 for 1 cycle; rd_pend[w]=~we[w]; cnt=MEM_LAT; go to ACCESS.
- IDLE, no req: outputs idle; gnt=0, rvalid=0.
- ACCESS: strobes and address held stable; gnt drops after its first cycle; cnt decrements each edge.
- ACCESS, edge with cnt==1:
  - If read: rdata<=mem_rdata, rvalid[w]=1, rd_pend[w]=0.
  - Strobes drop to 0; go to IDLE.
- Timing: the access occupies exactly MEM_LAT cycles. rvalid is asserted in the following IDLE cycle. Minimum spacing between grants is MEM_LAT+1 cycles.
- Writes produce no rvalid. A write is complete when the strobe drops.
- Requester drops req (or presents a new request) at the edge ending its gnt cycle. Withdrawing req before gnt is illegal; behaviour is unspecified and the bench must not do it.
- Requests arriving during ACCESS wait. The arbiter only samples req in IDLE.
- A port may re-request in the same IDLE cycle its rvalid is high; that cycle is eligible for arbitration.
- Arbitration (default): lowest index with req high wins, so the data port always beats fetch.
- Address and data are passed unmodified; alignment is the requester's responsibility.
- Elaboration error if NUM_PORTS<2 or MEM_LAT<1.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at rr_ptr and wraps from NUM_PORTS-1 to 0. On each grant, rr_ptr <= (w+1) mod NUM_PORTS. rr_ptr resets to 0.
- Undefined: fixed priority as above; rr_ptr logic is not synthesised.
- Handshake and timing are identical in both builds.

Test Plan:
1. NUM_PORTS=2, MEM_LAT=1. Port1 reads addr 0x40, memory returns 0xDEADBEEF. Expect: gnt[1] in cycle 1; mem_rd=1 only in cycle 1; rvalid[1]=1 with rdata=0xDEADBEEF in cycle 2; stall[1] high in cycles 0-1.
2. Both ports request at once: port0 writes 0x11 to 0x10, port1 reads 0x20. Fixed priority expects gnt[0] first with mem_wr=1, then gnt[1] 2 cycles later; port1 stall stays high until its rvalid.
3. MEM_LAT=3, port0 read. Expect mem_rd high for exactly 3 cycles and rvalid[0] on the 4th cycle after grant; a port1 request raised mid-access is granted in the cycle after rvalid[0].
4. Reset mid-access: MEM_LAT=3, pull reset_n low in the 2nd ACCESS cycle. Expect all outputs 0 the next cycle and no rvalid; a new request after release behaves as in test 1.
5. ARB_ROUND_ROBIN_EN, NUM_PORTS=3, all ports requesting continuously. Expect grant order 0,1,2,0,1,2.
6. Without the macro, the same stimulus gives 0,0,0…; port1 and port2 stall permanently (starvation is documented behaviour).

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// Arbitrates NUM_PORTS requesters onto one single-ported memory with a registered req/gnt handshake.
// Accesses last MEM_LAT cycles; define ARB_ROUND_ROBIN_EN for round-robin, otherwise port 0 has fixed priority.
module shared_mem_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        stall,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_rd,
  output logic                        mem_wr,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PW = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || MEM_LAT < 1) begin : g_bad_param
    $error("shared_mem_arbiter: NUM_PORTS must be 2..8 and MEM_LAT >= 1");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [PW-1:0]        sel_q;
  logic [NUM_PORTS-1:0] rd_pend_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [DATA_W-1:0]    mem_wdata_q;
  logic                 mem_rd_q;
  logic                 mem_wr_q;

  logic                 any_req;
  logic [PW-1:0]        win_d;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 win_we;

  assign any_req = |req;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic          found;

  // Search starts at rr_ptr_q and wraps; the first requester seen wins.
  always_comb begin
    win_d = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!found && req[(int'(rr_ptr_q) + k) % NUM_PORTS]) begin
        win_d = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
        found = 1'b1;
      end
    end
    rr_ptr_d = PW'((int'(win_d) + 1) % NUM_PORTS);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    win_d = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) win_d = PW'(k);
    end
  end
`endif

  always_comb begin
    win_addr  = addr[ADDR_W-1:0];
    win_wdata = wdata[DATA_W-1:0];
    win_we    = we[0];
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (win_d == PW'(k)) begin
        win_addr  = addr[k*ADDR_W +: ADDR_W];
        win_wdata = wdata[k*DATA_W +: DATA_W];
        win_we    = we[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      rd_pend_q   <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q            <= ACCESS;
            sel_q              <= win_d;
            mem_addr_q         <= win_addr;
            mem_wdata_q        <= win_wdata;
            mem_rd_q           <= ~win_we;
            mem_wr_q           <= win_we;
            gnt_q[win_d]       <= 1'b1;
            rd_pend_q[win_d]   <= ~win_we;
            cnt_q              <= CW'(MEM_LAT);
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - CW'(1);
          // Last access cycle: memory data is valid now, so capture it and release the bus.
          if (cnt_q == CW'(1)) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (mem_rd_q) begin
              rdata_q          <= mem_rdata;
              rvalid_q[sel_q]  <= 1'b1;
              rd_pend_q[sel_q] <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign stall     = (req & ~gnt_q) | (rd_pend_q & ~rvalid_q);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: instance A (2 ports, latency 1) and instance B (3 ports, latency 3).
// Read results are checked through per-instance scoreboard queues filled when requests are driven.
module tb_shared_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t exp_a_q[$];
  exp_t exp_b_q[$];

  // Instance A
  logic        ra_n;
  logic [1:0]  a_req, a_we;
  logic [63:0] a_addr, a_wdata;
  logic [1:0]  a_gnt, a_rvalid, a_stall;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        a_mrd, a_mwr;

  // Instance B
  logic        rb_n;
  logic [2:0]  b_req, b_we;
  logic [95:0] b_addr, b_wdata;
  logic [2:0]  b_gnt, b_rvalid, b_stall;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic        b_mrd, b_mwr;

  shared_mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_a (
    .clock(clk), .reset_n(ra_n), .req(a_req), .we(a_we), .addr(a_addr), .wdata(a_wdata),
    .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .stall(a_stall),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rd(a_mrd), .mem_wr(a_mwr),
    .mem_rdata(a_mrdata)
  );

  shared_mem_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_b (
    .clock(clk), .reset_n(rb_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .stall(b_stall),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rd(b_mrd), .mem_wr(b_mwr),
    .mem_rdata(b_mrdata)
  );

  // Memory models: fixed contents derived from the address, writes captured for checking.
  assign a_mrdata = (a_maddr == 32'h40) ? 32'hDEADBEEF : (32'hC0DE0000 | a_maddr);
  assign b_mrdata = 32'hC0DE0000 | b_maddr;

  logic [31:0] a_last_wr_addr, a_last_wr_data;
  always @(posedge clk) begin
    if (a_mwr) begin
      a_last_wr_addr <= a_maddr;
      a_last_wr_data <= a_mwdata;
    end
  end

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ra_n && a_rvalid != 2'b00) begin
      n_cmp++;
      if (exp_a_q.size() == 0) begin
        n_err++;
        $display("FAIL a_rvalid_unexpected got rvalid=%b rdata=%h want none", a_rvalid, a_rdata);
      end else begin
        e = exp_a_q.pop_front();
        if (a_rvalid !== (2'b01 << e.port) || a_rdata !== e.data) begin
          n_err++;
          $display("FAIL a_read_data got rvalid=%b rdata=%h want port %0d data %h",
                   a_rvalid, a_rdata, e.port, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rb_n && b_rvalid != 3'b000) begin
      n_cmp++;
      if (exp_b_q.size() == 0) begin
        n_err++;
        $display("FAIL b_rvalid_unexpected got rvalid=%b rdata=%h want none", b_rvalid, b_rdata);
      end else begin
        e = exp_b_q.pop_front();
        if (b_rvalid !== (3'b001 << e.port) || b_rdata !== e.data) begin
          n_err++;
          $display("FAIL b_read_data got rvalid=%b rdata=%h want port %0d data %h",
                   b_rvalid, b_rdata, e.port, e.data);
        end
      end
    end
  end

  task automatic push_a(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_a_q.push_back(e);
  endtask

  task automatic push_b(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_b_q.push_back(e);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ra_n = 1'b0; rb_n = 1'b0;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({a_gnt, a_rvalid, a_stall, a_mrd, a_mwr} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_a_ctrl got %b want 0", {a_gnt, a_rvalid, a_stall, a_mrd, a_mwr});
    end
    n_cmp++;
    if ({a_rdata, a_maddr, a_mwdata} !== 96'h0) begin
      n_err++;
      $display("FAIL reset_a_data got %h want 0", {a_rdata, a_maddr, a_mwdata});
    end
    n_cmp++;
    if ({b_gnt, b_rvalid, b_stall, b_mrd, b_mwr, b_rdata, b_maddr} !== 75'h0) begin
      n_err++;
      $display("FAIL reset_b got %h want 0", {b_gnt, b_rvalid, b_stall, b_mrd, b_mwr, b_rdata, b_maddr});
    end
    next_cyc();
    ra_n = 1'b1; rb_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_read_lat1();
    a_we = 2'b00;
    a_addr[63:32] = 32'h40;
    a_req = 2'b10;
    push_a(1, 32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if (a_stall[1] !== 1'b1 || a_gnt !== 2'b00) begin
      n_err++;
      $display("FAIL rd1_c0 got stall1=%b gnt=%b want 1 / 00", a_stall[1], a_gnt);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 2'b10 || a_mrd !== 1'b1 || a_mwr !== 1'b0 || a_maddr !== 32'h40 || a_stall[1] !== 1'b1) begin
      n_err++;
      $display("FAIL rd1_c1 got gnt=%b rd=%b wr=%b addr=%h stall1=%b want 10 1 0 40 1",
               a_gnt, a_mrd, a_mwr, a_maddr, a_stall[1]);
    end
    next_cyc();
    a_req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (a_mrd !== 1'b0 || a_rvalid !== 2'b10 || a_stall !== 2'b00 || a_gnt !== 2'b00) begin
      n_err++;
      $display("FAIL rd1_c2 got rd=%b rvalid=%b stall=%b gnt=%b want 0 10 00 00",
               a_mrd, a_rvalid, a_stall, a_gnt);
    end
    next_cyc();
  endtask

  task automatic test_fixed_priority();
    a_we = 2'b01;
    a_addr = {32'h20, 32'h10};
    a_wdata = {32'h0, 32'h11};
    a_req = 2'b11;
    push_a(1, 32'hC0DE0020);
    @(negedge clk);
    n_cmp++;
    if (a_stall !== 2'b11) begin
      n_err++;
      $display("FAIL pri_c0_stall got %b want 11", a_stall);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 2'b01 || a_mwr !== 1'b1 || a_mrd !== 1'b0 || a_maddr !== 32'h10 ||
        a_mwdata !== 32'h11 || a_stall[1] !== 1'b1) begin
      n_err++;
      $display("FAIL pri_c1_write got gnt=%b wr=%b rd=%b addr=%h wdata=%h stall1=%b want 01 1 0 10 11 1",
               a_gnt, a_mwr, a_mrd, a_maddr, a_mwdata, a_stall[1]);
    end
    next_cyc();
    a_req = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 2'b00 || a_mwr !== 1'b0 || a_stall[1] !== 1'b1 || a_rvalid !== 2'b00) begin
      n_err++;
      $display("FAIL pri_c2 got gnt=%b wr=%b stall1=%b rvalid=%b want 00 0 1 00",
               a_gnt, a_mwr, a_stall[1], a_rvalid);
    end
    n_cmp++;
    if (a_last_wr_addr !== 32'h10 || a_last_wr_data !== 32'h11) begin
      n_err++;
      $display("FAIL pri_mem_write got addr=%h data=%h want 10 11", a_last_wr_addr, a_last_wr_data);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (a_gnt !== 2'b10 || a_mrd !== 1'b1 || a_maddr !== 32'h20 || a_stall[1] !== 1'b1) begin
      n_err++;
      $display("FAIL pri_c3_read got gnt=%b rd=%b addr=%h stall1=%b want 10 1 20 1",
               a_gnt, a_mrd, a_maddr, a_stall[1]);
    end
    next_cyc();
    a_req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (a_rvalid !== 2'b10 || a_stall !== 2'b00) begin
      n_err++;
      $display("FAIL pri_c4 got rvalid=%b stall=%b want 10 00", a_rvalid, a_stall);
    end
    next_cyc();
  endtask

  task automatic test_lat3();
    int mrd_cnt;
    bit seen;
    mrd_cnt = 0;
    b_we = 3'b000;
    b_addr[31:0] = 32'h30;
    b_req = 3'b001;
    push_b(0, 32'hC0DE0030);
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (b_gnt !== 3'b001) begin
      n_err++;
      $display("FAIL lat3_gnt0 got %b want 001", b_gnt);
    end
    mrd_cnt += int'(b_mrd);
    next_cyc();
    b_req = 3'b010;
    b_addr[63:32] = 32'h34;
    push_b(1, 32'hC0DE0034);
    @(negedge clk);
    mrd_cnt += int'(b_mrd);
    next_cyc();
    @(negedge clk);
    mrd_cnt += int'(b_mrd);
    n_cmp++;
    if (b_stall[1] !== 1'b1 || b_gnt !== 3'b000) begin
      n_err++;
      $display("FAIL lat3_wait got stall1=%b gnt=%b want 1 000", b_stall[1], b_gnt);
    end
    next_cyc();
    @(negedge clk);
    mrd_cnt += int'(b_mrd);
    n_cmp++;
    if (b_rvalid !== 3'b001 || b_gnt !== 3'b000) begin
      n_err++;
      $display("FAIL lat3_rvalid0 got rvalid=%b gnt=%b want 001 000", b_rvalid, b_gnt);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (b_gnt !== 3'b010) begin
      n_err++;
      $display("FAIL lat3_gnt1 got %b want 010", b_gnt);
    end
    n_cmp++;
    if (mrd_cnt != 3) begin
      n_err++;
      $display("FAIL lat3_rd_cycles got %0d want 3", mrd_cnt);
    end
    next_cyc();
    b_req = 3'b000;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (b_rvalid[1]) seen = 1'b1;
      next_cyc();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL lat3_rvalid1_timeout got none want rvalid[1]");
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    bit seen;
    b_we = 3'b000;
    b_addr[31:0] = 32'h50;
    b_req = 3'b001;
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (b_gnt !== 3'b001) begin
      n_err++;
      $display("FAIL rstmid_gnt got %b want 001", b_gnt);
    end
    next_cyc();
    b_req = 3'b000;
    rb_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (b_mrd !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_access2 got rd=%b want 1", b_mrd);
    end
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if ({b_gnt, b_rvalid, b_stall, b_mrd, b_mwr} !== 11'h0 || b_rdata !== 32'h0 ||
        b_maddr !== 32'h0 || b_mwdata !== 32'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs got gnt=%b rv=%b stall=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want all 0",
               b_gnt, b_rvalid, b_stall, b_mrd, b_mwr, b_rdata, b_maddr, b_mwdata);
    end
    next_cyc();
    rb_n = 1'b1;
    repeat (5) next_cyc();
    b_addr[63:32] = 32'h40;
    b_req = 3'b010;
    push_b(1, 32'hC0DE0040);
    next_cyc();
    @(negedge clk);
    n_cmp++;
    if (b_gnt !== 3'b010 || b_mrd !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_regrant got gnt=%b rd=%b want 010 1", b_gnt, b_mrd);
    end
    next_cyc();
    b_req = 3'b000;
    lat = 1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (b_rvalid[1]) seen = 1'b1;
      else begin
        lat++;
        next_cyc();
      end
    end
    n_cmp++;
    if (!seen || lat != 3) begin
      n_err++;
      $display("FAIL rstmid_rvalid_lat got seen=%0d lat=%0d want 1 3", seen, lat);
    end
    next_cyc();
  endtask

  task automatic test_arb_stream();
    int exp_order[6];
    int got;
    int g;
    rb_n = 1'b0;
    next_cyc();
    rb_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_order[k] = k % 3;
`else
      exp_order[k] = 0;
`endif
      push_b(exp_order[k], 32'hC0DE0060 + 32'(4 * exp_order[k]));
    end
    b_we = 3'b000;
    b_addr = {32'h68, 32'h64, 32'h60};
    b_req = 3'b111;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      if (b_gnt != 3'b000) begin
        g = -1;
        for (int i = 0; i < 3; i++) if (b_gnt[i]) g = i;
        n_cmp++;
        if ($countones(b_gnt) != 1 || g != exp_order[got]) begin
          n_err++;
          $display("FAIL arb_order[%0d] got gnt=%b want port %0d", got, b_gnt, exp_order[got]);
        end
`ifndef ARB_ROUND_ROBIN_EN
        n_cmp++;
        if (b_stall[2:1] !== 2'b11) begin
          n_err++;
          $display("FAIL arb_starve_stall got %b want 11", b_stall[2:1]);
        end
`endif
        got++;
      end
      next_cyc();
    end
    b_req = 3'b000;
    n_cmp++;
    if (got != 6) begin
      n_err++;
      $display("FAIL arb_grant_count got %0d want 6", got);
    end
    repeat (6) next_cyc();
  endtask

  initial begin
    test_reset();
    test_read_lat1();
    test_fixed_priority();
    test_lat3();
    test_reset_mid_access();
    test_arb_stream();
    repeat (2) next_cyc();
    n_cmp++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got a=%0d b=%0d pending want 0 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
